// File: rtl/game_ctrl.sv
// game_ctrl: debounces start/clear buttons and sequences the countdown timer through INIT/IDLE/RUN/OVER.
// Latency: raw button edge to state change is DEBOUNCE_CYCLES+4 cycles; game_over to OVER is 1 cycle.
// Backpressure: none; presses arriving in INIT are dropped. Optional auto-restart: GAME_CTRL_AUTO_RESTART_EN.
module game_ctrl #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int BLINK_CYCLES    = 25000000,
   parameter int RESET_PULSE     = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic       game_over,
   output logic       timer_reset,
   output logic       timer_start,
   output logic       running,
   output logic       led_over,
   output logic [1:0] state
);

   localparam int DBC_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam int INIT_W  = (RESET_PULSE > 1) ? $clog2(RESET_PULSE) : 1;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_RUN  = 2'd2,
      ST_OVER = 2'd3
   } state_t;

   // Button lanes: index 0 is start, index 1 is clear.
   logic [1:0]       btn_raw;
   logic [1:0]       sync_1;
   logic [1:0]       sync_2;
   logic [1:0]       dbc_level;
   logic [1:0]       dbc_level_d;
   logic [1:0]       press;
   logic [DBC_W-1:0] dbc_cnt [2];

   logic             start_press;
   logic             clear_press;

   state_t              st;
   state_t              st_nxt;
   logic [INIT_W-1:0]   init_cnt;
   logic [BLINK_W-1:0]  blink_cnt;
   logic                init_done;

`ifdef GAME_CTRL_AUTO_RESTART_EN
   // Set by a start press in OVER so the next INIT runs straight into RUN.
   logic restart;
   logic restart_nxt;
`endif

   assign btn_raw     = {btn_clear, btn_start};
   assign start_press = press[0];
   assign clear_press = press[1];
   assign init_done   = (init_cnt == INIT_W'(RESET_PULSE - 1));
   assign state       = st;

   // Two-flop synchronizer bringing the raw buttons into the clock domain.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_1 <= '0;
         sync_2 <= '0;
      end else begin
         sync_1 <= btn_raw;
         sync_2 <= sync_1;
      end
   end

   // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clock) begin
      if (reset) begin
         dbc_level <= '0;
         for (int i = 0; i < 2; i++) begin
            dbc_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync_2[i] == dbc_level[i]) begin
               dbc_cnt[i] <= '0;
            end else if (dbc_cnt[i] == DBC_W'(DEBOUNCE_CYCLES - 1)) begin
               dbc_level[i] <= sync_2[i];
               dbc_cnt[i]   <= '0;
            end else begin
               dbc_cnt[i] <= dbc_cnt[i] + DBC_W'(1);
            end
         end
      end
   end

   // Press pulse: one cycle after the debounced level rises; releases are ignored.
   always_ff @(posedge clock) begin
      if (reset) begin
         dbc_level_d <= '0;
         press       <= '0;
      end else begin
         dbc_level_d <= dbc_level;
         press       <= dbc_level & ~dbc_level_d;
      end
   end

   // Next-state logic: clear beats start beats game_over.
   always_comb begin
      st_nxt = st;
`ifdef GAME_CTRL_AUTO_RESTART_EN
      restart_nxt = restart;
`endif
      case (st)
         ST_INIT: begin
            // Presses are dropped here; only the pulse counter matters.
            if (init_done) begin
`ifdef GAME_CTRL_AUTO_RESTART_EN
               // A clear landing on the last INIT cycle still cancels the restart.
               if (restart && !clear_press) begin
                  st_nxt = ST_RUN;
               end else begin
                  st_nxt = ST_IDLE;
               end
               restart_nxt = 1'b0;
`else
               st_nxt = ST_IDLE;
`endif
            end
         end
         ST_IDLE: begin
            if (clear_press) begin
               st_nxt = ST_INIT;
            end else if (start_press) begin
               st_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (clear_press) begin
               st_nxt = ST_INIT;
            end else if (game_over) begin
               st_nxt = ST_OVER;
            end
         end
         ST_OVER: begin
            if (clear_press) begin
               st_nxt = ST_INIT;
`ifdef GAME_CTRL_AUTO_RESTART_EN
            end else if (start_press) begin
               st_nxt      = ST_INIT;
               restart_nxt = 1'b1;
`endif
            end
         end
         default: st_nxt = ST_INIT;
      endcase
`ifdef GAME_CTRL_AUTO_RESTART_EN
      // Any clear press returns to the normal INIT -> IDLE flow.
      if (clear_press) begin
         restart_nxt = 1'b0;
      end
`endif
   end

   // State register and registered outputs derived from the next state.
   always_ff @(posedge clock) begin
      if (reset) begin
         st          <= ST_INIT;
         timer_reset <= 1'b1;
         timer_start <= 1'b0;
         running     <= 1'b0;
      end else begin
         st          <= st_nxt;
         timer_reset <= (st_nxt == ST_INIT);
         timer_start <= (st_nxt == ST_RUN) && (st != ST_RUN);
         running     <= (st_nxt == ST_RUN);
      end
   end

`ifdef GAME_CTRL_AUTO_RESTART_EN
   // Restart flag register.
   always_ff @(posedge clock) begin
      if (reset) begin
         restart <= 1'b0;
      end else begin
         restart <= restart_nxt;
      end
   end
`endif

   // INIT counter: counts cycles spent in INIT, restarting at 0 on every entry.
   always_ff @(posedge clock) begin
      if (reset) begin
         init_cnt <= '0;
      end else if ((st == ST_INIT) && (st_nxt == ST_INIT)) begin
         init_cnt <= init_cnt + INIT_W'(1);
      end else begin
         init_cnt <= '0;
      end
   end

   // Blink generator: led_over lights on OVER entry and toggles every BLINK_CYCLES.
   always_ff @(posedge clock) begin
      if (reset) begin
         blink_cnt <= '0;
         led_over  <= 1'b0;
      end else if (st_nxt == ST_OVER) begin
         if (st != ST_OVER) begin
            blink_cnt <= '0;
            led_over  <= 1'b1;
         end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            led_over  <= ~led_over;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end
      end else begin
         blink_cnt <= '0;
         led_over  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios with literal expectations, then randomized buttons,
// game_over and resets, with every cycle compared against a behavioural model of the sequencer.
module tb_game_ctrl;

   localparam int DEB   = 4;
   localparam int BLINK = 8;
   localparam int RP    = 4;
`ifdef GAME_CTRL_AUTO_RESTART_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clock;
   logic       reset;
   logic       btn_start;
   logic       btn_clear;
   logic       game_over;
   logic       timer_reset;
   logic       timer_start;
   logic       running;
   logic       led_over;
   logic [1:0] state;

   int n_cmp = 0;
   int n_err = 0;

   game_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .BLINK_CYCLES   (BLINK),
      .RESET_PULSE    (RP)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .btn_start  (btn_start),
      .btn_clear  (btn_clear),
      .game_over  (game_over),
      .timer_reset(timer_reset),
      .timer_start(timer_start),
      .running    (running),
      .led_over   (led_over),
      .state      (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Buttons: each raw level is seen two edges late; a level is accepted once the last DEB
   // seen samples all disagree with the current accepted level; a press follows one cycle later.
   bit m_valid = 1'b0;
   bit m_p1 [2];
   bit m_p2 [2];
   bit m_hist [2][DEB];
   bit m_lvl [2];
   bit m_lvl_d [2];
   bit m_press [2];
   int m_st;
   int m_init_age;
   int m_over_age;
   bit m_restart;
   bit m_treset, m_tstart, m_run, m_led;

   bit sp, cp, s_smp, all_diff, raw;
   int ns;

   always @(posedge clock) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            m_p1[b] = 0; m_p2[b] = 0; m_lvl[b] = 0; m_lvl_d[b] = 0; m_press[b] = 0;
            for (int i = 0; i < DEB; i++) m_hist[b][i] = 0;
         end
         m_st = 0; m_init_age = 0; m_over_age = 0; m_restart = 0;
         m_treset = 1; m_tstart = 0; m_run = 0; m_led = 0;
         m_valid = 1;
      end else begin
         sp = m_press[0];
         cp = m_press[1];
         ns = m_st;
         case (m_st)
            0: if (m_init_age == RP - 1) ns = (m_restart && !cp) ? 2 : 1;
            1: if (cp) ns = 0; else if (sp) ns = 2;
            2: if (cp) ns = 0; else if (game_over) ns = 3;
            default: if (cp) ns = 0; else if (AUTO && sp) ns = 0;
         endcase
         if (AUTO && m_st == 3 && !cp && sp) m_restart = 1;
         if (m_st == 0 && ns != 0) m_restart = 0;
         if (cp) m_restart = 0;
         m_init_age = (m_st == 0 && ns == 0) ? m_init_age + 1 : 0;
         m_over_age = (m_st == 3 && ns == 3) ? m_over_age + 1 : 0;
         m_treset = (ns == 0);
         m_tstart = (ns == 2) && (m_st != 2);
         m_run    = (ns == 2);
         m_led    = (ns == 3) && (((m_over_age / BLINK) % 2) == 0);
         m_st = ns;
         for (int b = 0; b < 2; b++) begin
            raw = (b == 0) ? btn_start : btn_clear;
            s_smp = m_p2[b];
            m_p2[b] = m_p1[b];
            m_p1[b] = raw;
            for (int i = DEB - 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
            m_hist[b][0] = s_smp;
            all_diff = 1;
            for (int i = 0; i < DEB; i++) if (m_hist[b][i] == m_lvl[b]) all_diff = 0;
            m_press[b] = m_lvl[b] && !m_lvl_d[b];
            m_lvl_d[b] = m_lvl[b];
            if (all_diff) m_lvl[b] = !m_lvl[b];
         end
      end
   end

   // Per-cycle comparison against the model, sampled just after the active edge.
   always @(posedge clock) begin
      #1;
      if (m_valid) begin
         chk("m_state", state, m_st);
         chk("m_timer_reset", timer_reset, m_treset);
         chk("m_timer_start", timer_start, m_tstart);
         chk("m_running", running, m_run);
         chk("m_led_over", led_over, m_led);
      end
   end

   // ---------------- stimulus ----------------
   int first;
   int pulses;
   int hold_s, hold_c, hold_g;

   initial begin
      reset = 1'b1; btn_start = 1'b0; btn_clear = 1'b0; game_over = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_state", state, 0);
      chk("rst_timer_reset", timer_reset, 1);
      chk("rst_running", running, 0);
      chk("rst_led", led_over, 0);
      reset = 1'b0;

      // Reset release: four INIT cycles with timer_reset high, then IDLE.
      for (int i = 0; i < 4; i++) begin
         chk("init_state", state, 0);
         chk("init_timer_reset", timer_reset, 1);
         chk("init_timer_start", timer_start, 0);
         @(negedge clock);
      end
      chk("idle_state", state, 1);
      chk("idle_timer_reset", timer_reset, 0);

      // Short glitch on start is rejected.
      btn_start = 1'b1;
      repeat (2) @(negedge clock);
      btn_start = 1'b0;
      repeat (10) @(negedge clock);
      chk("glitch_state", state, 1);

      // Held start: RUN after DEB+4 cycles with a single timer_start pulse.
      btn_start = 1'b1;
      first = -1; pulses = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clock);
         if (timer_start) pulses++;
         if (state == 2 && first < 0) first = i;
      end
      btn_start = 1'b0;
      chk("start_latency", first, 8);
      chk("start_pulses", pulses, 1);
      chk("run_running", running, 1);

      // game_over: OVER next cycle, blink with period 2*BLINK, start ignored.
      game_over = 1'b1;
      @(negedge clock);
      chk("over_state", state, 3);
      chk("over_running", running, 0);
      chk("over_led_entry", led_over, 1);
      btn_start = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clock);
         if (k == 7)  chk("over_led_k7", led_over, 1);
         if (k == 8)  chk("over_led_k8", led_over, 0);
         if (k == 10) btn_start = 1'b0;
      end
      chk("over_led_k16", led_over, 1);
      chk("over_start_ignored", state, 3);

      // Clear from OVER: INIT for RP cycles, then IDLE with led off.
      btn_clear = 1'b1;
      first = -1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clock);
         if (state == 0) begin
            first = i;
            break;
         end
      end
      chk("clear_latency", first, 8);
      for (int j = 0; j < 4; j++) begin
         chk("clr_init_state", state, 0);
         chk("clr_init_treset", timer_reset, 1);
         @(negedge clock);
      end
      chk("clr_idle_state", state, 1);
      chk("clr_idle_led", led_over, 0);
      btn_clear = 1'b0;
      game_over = 1'b0;
      repeat (20) @(negedge clock);

      // Clear press coinciding with game_over in RUN goes to INIT, never OVER.
      btn_start = 1'b1;
      repeat (8) @(negedge clock);
      chk("align_run", state, 2);
      repeat (4) @(negedge clock);
      btn_start = 1'b0;
      repeat (20) @(negedge clock);
      btn_clear = 1'b1;
      repeat (7) @(negedge clock);
      chk("align_pre", state, 2);
      game_over = 1'b1;
      @(negedge clock);
      chk("align_state", state, 0);
      repeat (4) @(negedge clock);
      btn_clear = 1'b0;
      repeat (10) @(negedge clock);
      chk("align_idle", state, 1);
      game_over = 1'b0;
      repeat (20) @(negedge clock);

`ifdef GAME_CTRL_AUTO_RESTART_EN
      // Auto restart: start in OVER -> INIT for RP cycles -> RUN with one pulse.
      btn_start = 1'b1;
      repeat (12) @(negedge clock);
      btn_start = 1'b0;
      repeat (20) @(negedge clock);
      game_over = 1'b1;
      @(negedge clock);
      game_over = 1'b0;
      chk("auto_over", state, 3);
      btn_start = 1'b1;
      repeat (8) @(negedge clock);
      chk("auto_init", state, 0);
      repeat (4) @(negedge clock);
      chk("auto_run", state, 2);
      chk("auto_pulse", timer_start, 1);
      @(negedge clock);
      chk("auto_pulse_end", timer_start, 0);
      repeat (2) @(negedge clock);
      btn_start = 1'b0;
      repeat (20) @(negedge clock);
      btn_clear = 1'b1;
      repeat (12) @(negedge clock);
      btn_clear = 1'b0;
      repeat (20) @(negedge clock);
      chk("auto_back_idle", state, 1);
`endif

      // One-cycle reset on the timer_start cycle in RUN cancels everything.
      btn_start = 1'b1;
      repeat (8) @(negedge clock);
      chk("rst_mid_run", state, 2);
      btn_start = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("rst_mid_state", state, 0);
      chk("rst_mid_treset", timer_reset, 1);
      chk("rst_mid_running", running, 0);
      chk("rst_mid_tstart", timer_start, 0);
      repeat (10) @(negedge clock);
      chk("rst_mid_idle", state, 1);

      // Randomized phase, checked by the model every cycle.
      hold_s = 0; hold_c = 0; hold_g = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clock);
         if (reset) reset = 1'b0;
         else if ($urandom_range(0, 299) == 0) reset = 1'b1;
         if (hold_s == 0) begin
            btn_start = 1'($urandom_range(0, 1));
            hold_s = $urandom_range(1, 9);
         end else hold_s--;
         if (hold_c == 0) begin
            btn_clear = ($urandom_range(0, 3) == 0);
            hold_c = $urandom_range(1, 9);
         end else hold_c--;
         if (hold_g == 0) begin
            game_over = 1'($urandom_range(0, 1));
            hold_g = $urandom_range(1, 40);
         end else hold_g--;
      end
      @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
